// File: rtl/fifo_rd_stream_if.sv
// Output stream bundle of the FIFO read-side drain stage.
// Carries payload, end-of-packet flag and the valid/ready pair.
interface fifo_rd_stream_if #(
  parameter int DATA_W = 65
);
  logic              m_valid;
  logic [DATA_W-2:0] m_data;
  logic              m_last;
  logic              m_ready;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side drain of the clock-crossing FIFO: hides the FIFO's
// registered read latency behind a 2-entry buffer and counts beats.
module fifo_rd_stream #(
  parameter int DATA_W = 65,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_fire,
  input  logic [DATA_W-1:0] fifo_rd_data,
  fifo_rd_stream_if.master  m,
  output logic [31:0]       beat_count,
  output logic [CNT_W-1:0]  pkt_count
);

  logic              inflight;
  logic [DATA_W-1:0] buf_q [2];
  logic              wp;
  logic              rp;
  logic [1:0]        count;
  logic [1:0]        occ;
  logic              pop;

  assign pop = m.m_valid && m.m_ready;
  assign occ = count + {1'b0, inflight};

  // Reissue on a pop even when full: the freed slot is
  // refilled by the word landing one cycle later.
  assign fifo_rd_fire = !rst && !fifo_empty
                     && ((occ < 2'd2) || pop);

  assign m.m_valid = (count != 2'd0);
  assign {m.m_last, m.m_data} = buf_q[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight   <= 1'b0;
      wp         <= 1'b0;
      rp         <= 1'b0;
      count      <= 2'd0;
      beat_count <= '0;
      pkt_count  <= '0;
    end else begin
      inflight <= fifo_rd_fire;
      if (inflight)
        wp <= ~wp;
      if (pop)
        rp <= ~rp;
      count <= count + {1'b0, inflight}
                     - {1'b0, pop};
      if (pop)
        beat_count <= beat_count + 32'd1;
      if (pop && m.m_last)
        pkt_count <= pkt_count + 1'b1;
    end
  end

  // Storage is not reset; count alone says what is live.
  always_ff @(posedge clk) begin
    if (inflight)
      buf_q[wp] <= fifo_rd_data;
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO model, scoreboard,
// vector table and hand-written corner sequences.
module tb_fifo_rd_stream;

  localparam int DW = 65;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_fire;
  logic [DW-1:0] fifo_rd_data = '0;
  logic [31:0]   beat_count;
  logic [CW-1:0] pkt_count;

  fifo_rd_stream_if #(.DATA_W(DW)) s_if ();

  fifo_rd_stream #(
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_rd_fire(fifo_rd_fire),
    .fifo_rd_data(fifo_rd_data),
    .m           (s_if),
    .beat_count  (beat_count),
    .pkt_count   (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rdy;
    bit          hold;
    bit          fire;
    bit          valid;
    bit          dchk;
    logic [64:0] word;
    logic [31:0] beat;
    logic [15:0] pkt;
  } vec_t;

  logic [DW-1:0] fq [$];
  logic [DW-1:0] sb [$];
  bit            fire_d;
  bit            last_pop;
  int            out;
  int            npop;
  int            errors;
  int            checks;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    sb.push_back(w);
  endtask

  // One clock: drive at negedge, sample #1 later.
  task automatic cycle(input bit rdy,
                       input bit hold,
                       input bit r);
    logic [DW-1:0] w;
    @(negedge clk);
    if (fire_d) begin
      if (fq.size() == 0)
        chk("fifo_underrun", 1, 0);
      else
        fifo_rd_data = fq.pop_front();
    end
    rst = r;
    s_if.m_ready = rdy;
    fifo_empty = hold || (fq.size() == 0);
    #1;
    fire_d = fifo_rd_fire;
    last_pop = 1'b0;
    if (r) begin
      chk("rst_fire", fifo_rd_fire, 0);
      for (int i = 0; i < out; i++)
        if (sb.size() != 0)
          void'(sb.pop_front());
      out = 0;
    end else begin
      last_pop = s_if.m_valid && rdy;
      if (last_pop) begin
        npop++;
        if (sb.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          w = sb.pop_front();
          chk("beat", {s_if.m_last, s_if.m_data}, w);
        end
      end
      out = out + int'(fifo_rd_fire) - int'(last_pop);
      chk("occ_le_2", out <= 2, 1);
    end
  endtask

  vec_t tbl [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fires;
    int n;
    int lasts;
    int base;
    bit seen;
    int bubbles;
    logic [DW-1:0] w;

    s_if.m_ready = 1'b0;
    errors = 0;
    checks = 0;
    out = 0;
    npop = 0;
    fire_d = 1'b0;

    tbl[0] = '{1, 1, 0, 0, 0, '0, 0, 0};
    tbl[1] = '{1, 0, 1, 0, 0, '0, 0, 0};
    tbl[2] = '{1, 0, 0, 0, 0, '0, 0, 0};
    tbl[3] = '{1, 0, 0, 1, 1,
               65'h1_0000_0000_DEAD_BEEF, 0, 0};
    tbl[4] = '{1, 0, 0, 0, 0, '0, 1, 1};

    // Reset with a non-empty FIFO, then single word.
    push(65'h1_0000_0000_DEAD_BEEF);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    foreach (tbl[i]) begin
      cycle(tbl[i].rdy, tbl[i].hold, 0);
      chk($sformatf("v%0d_fire", i),
          fifo_rd_fire, tbl[i].fire);
      chk($sformatf("v%0d_valid", i),
          s_if.m_valid, tbl[i].valid);
      if (tbl[i].dchk)
        chk($sformatf("v%0d_word", i),
            {s_if.m_last, s_if.m_data}, tbl[i].word);
      chk($sformatf("v%0d_beat", i),
          beat_count, tbl[i].beat);
      chk($sformatf("v%0d_pkt", i),
          pkt_count, tbl[i].pkt);
    end

    // Streaming: 8 beats, no bubble after the first.
    for (int i = 0; i < 8; i++)
      push({i == 7, 64'(i)});
    n = 0;
    seen = 0;
    bubbles = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      cycle(1, 0, 0);
      if (last_pop) begin
        n++;
        seen = 1;
      end else if (seen) begin
        bubbles++;
      end
    end
    chk("stream_beats", n, 8);
    chk("stream_bubbles", bubbles, 0);
    cycle(1, 1, 0);
    chk("stream_pkt", pkt_count, 2);
    chk("stream_beat_cnt", beat_count, 9);

    // Backpressure: 5 words, ready low for 10 cycles.
    for (int i = 0; i < 5; i++)
      push({i == 4, 64'h0B00 + 64'(i)});
    fires = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(0, 0, 0);
      fires += int'(fire_d);
      if (s_if.m_valid)
        chk("bp_hold", {s_if.m_last, s_if.m_data},
            65'h0B00);
    end
    chk("bp_fires", fires, 2);
    chk("bp_valid", s_if.m_valid, 1);
    for (int c = 0; c < 50; c++) begin
      if (sb.size() == 0 && out == 0)
        break;
      cycle(1, 0, 0);
    end
    chk("bp_drained", sb.size(), 0);
    cycle(1, 1, 0);
    chk("bp_beat_cnt", beat_count, 14);
    chk("bp_pkt", pkt_count, 3);

    // Random ready and random empty over 1000 words.
    cycle(0, 1, 1);
    cycle(0, 1, 0);
    lasts = 0;
    for (int i = 0; i < 1000; i++) begin
      w = {$urandom_range(3) == 0,
           {$urandom, $urandom}};
      lasts += int'(w[DW-1]);
      push(w);
    end
    n = 0;
    while (n < 20000 && (sb.size() != 0 || out != 0)) begin
      cycle($urandom_range(1) == 1,
            $urandom_range(2) == 0, 0);
      n++;
    end
    chk("rand_done", n < 20000, 1);
    cycle(0, 1, 0);
    chk("rand_beat_cnt", beat_count, 1000);
    chk("rand_pkt", pkt_count, lasts);

    // Beat counter wraps from all-ones.
    push({1'b1, 64'h55});
    for (int c = 0; c < 10 && !s_if.m_valid; c++)
      cycle(0, 0, 0);
    chk("wrap_valid", s_if.m_valid, 1);
    force dut.beat_count = 32'hFFFF_FFFF;
    cycle(0, 1, 0);
    release dut.beat_count;
    chk("wrap_pre", beat_count, 32'hFFFF_FFFF);
    cycle(1, 1, 0);
    cycle(0, 1, 0);
    chk("wrap_zero", beat_count, 0);

    // Reset with a word buffered and another in flight.
    for (int i = 0; i < 4; i++)
      push({i == 3, 64'h0C0 + 64'(i)});
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("mid_fire_cnt", out, 2);
    cycle(0, 0, 1);
    cycle(0, 1, 0);
    chk("mid_valid0", s_if.m_valid, 0);
    for (int c = 0; c < 4; c++) begin
      cycle(1, 1, 0);
      chk("mid_no_capture", s_if.m_valid, 0);
    end
    for (int c = 0; c < 30; c++) begin
      if (sb.size() == 0 && out == 0)
        break;
      cycle(1, 0, 0);
    end
    chk("mid_drained", sb.size(), 0);
    cycle(1, 1, 0);
    chk("mid_beat_cnt", beat_count, 2);
    chk("mid_pkt", pkt_count, 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
